// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with prescaler, edge/center-aligned counting and shadowed
// duty/mode registers committed at period boundaries via request/acknowledge.
module pwm_multi_channel #(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned DUTY_W  = 8,
    parameter int unsigned PRESC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        en_out,
    input  logic [NUM_CH-1:0]        en_pwm,
    input  logic [NUM_CH*DUTY_W-1:0] duty,
    input  logic [PRESC_W-1:0]       prescale,
    input  logic                     center_mode,
    input  logic                     load_req,
    output logic                     upd_pending,
    output logic                     upd_ack,
    output logic                     period_tick,
    output logic [NUM_CH-1:0]        out
);

    localparam logic [DUTY_W-1:0] CNT_MAX = {DUTY_W{1'b1}};
    localparam logic [DUTY_W-1:0] CNT_TOP = CNT_MAX - DUTY_W'(1);
    localparam logic [DUTY_W-1:0] CNT_ONE = DUTY_W'(1);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    logic [PRESC_W-1:0]             presc_cnt;
    logic [DUTY_W-1:0]              cnt;
    logic [DUTY_W-1:0]              cnt_nxt;
    dir_e                           dir;
    dir_e                           dir_nxt;
    logic [NUM_CH-1:0][DUTY_W-1:0]  duty_sh;
    logic                           mode_sh;
    logic                           tick;
    logic                           boundary;
    logic                           commit;
    logic [NUM_CH-1:0]              pwm;

    assign tick = (presc_cnt >= prescale);

    // State register: counter, direction, shadows, handshake and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt   <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            duty_sh     <= '0;
            mode_sh     <= 1'b0;
            upd_pending <= 1'b0;
            upd_ack     <= 1'b0;
            period_tick <= 1'b0;
            out         <= '0;
        end else begin
            presc_cnt   <= tick ? '0 : presc_cnt + PRESC_W'(1);
            cnt         <= cnt_nxt;
            dir         <= dir_nxt;
            period_tick <= boundary;
            upd_ack     <= commit;
            if (commit) begin
                duty_sh     <= duty;
                mode_sh     <= center_mode;
                upd_pending <= 1'b0;
            end else if (load_req) begin
                upd_pending <= 1'b1;
            end
            out <= en_out & (~en_pwm | pwm);
        end
    end

    // Next counter value/direction; boundary is the tick that lands on zero
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        boundary = 1'b0;
        if (tick) begin
            if (!mode_sh) begin
                if (cnt == CNT_TOP) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + DUTY_W'(1);
                end
            end else if (dir == DIR_UP) begin
                if (cnt == CNT_TOP) begin
                    cnt_nxt = cnt - DUTY_W'(1);
                    dir_nxt = DIR_DOWN;
                end else begin
                    cnt_nxt = cnt + DUTY_W'(1);
                end
            end else begin
                if (cnt == CNT_ONE) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt - DUTY_W'(1);
                end
            end
        end
        // A new period (and any newly committed mode) always starts counting up
        if (boundary) dir_nxt = DIR_UP;
    end

    // Commit decision and per-channel compare levels
    always_comb begin
        commit = boundary & (upd_pending | load_req);
        pwm    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm[i] = (cnt < duty_sh[i]);
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: a phase-based reference model pushes
// expected registered outputs per cycle; waveform statistics are checked too.
module tb_pwm_multi_channel;

    localparam int unsigned NUM_CH  = 16;
    localparam int unsigned DUTY_W  = 8;
    localparam int unsigned PRESC_W = 8;
    localparam int          MAXV    = (1 << DUTY_W) - 1;

    typedef struct packed {
        logic [NUM_CH-1:0] out;
        logic              pt;
        logic              ack;
        logic              pend;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        en_out = '0;
    logic [NUM_CH-1:0]        en_pwm = '0;
    logic [NUM_CH*DUTY_W-1:0] duty = '0;
    logic [PRESC_W-1:0]       prescale = '0;
    logic                     center_mode = 1'b0;
    logic                     load_req = 1'b0;
    logic                     upd_pending;
    logic                     upd_ack;
    logic                     period_tick;
    logic [NUM_CH-1:0]        out;

    pwm_multi_channel #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .en_out(en_out), .en_pwm(en_pwm), .duty(duty),
        .prescale(prescale), .center_mode(center_mode), .load_req(load_req),
        .upd_pending(upd_pending), .upd_ack(upd_ack), .period_tick(period_tick),
        .out(out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    exp_t sb_q[$];

    // reference model state
    int                m_presc, m_phase;
    logic              m_mode, m_pend, m_pt, m_ack;
    logic [NUM_CH-1:0] m_out;
    logic [DUTY_W-1:0] m_duty [NUM_CH];

    // per-run statistics
    int   st_n, st_hi0, st_hi1, st_hi2, st_pt, st_pt_pos, st_ack;
    logic [NUM_CH-1:0] st_or;
    logic hist [2048];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0; m_phase = 0; m_mode = 1'b0; m_pend = 1'b0;
        m_pt = 1'b0; m_ack = 1'b0; m_out = '0;
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = '0;
    endtask

    task automatic set_duty(input int ch, input int val);
        duty[ch*DUTY_W +: DUTY_W] = DUTY_W'(val);
    endtask

    // one clock: predict, push, clock, pop and compare
    task automatic step();
        exp_t e;
        logic tick, bnd;
        int   per, cnt_v;
        if (rst) begin
            model_reset();
        end else begin
            tick  = (m_presc >= int'(prescale));
            per   = m_mode ? 2 * (MAXV - 1) : MAXV;
            bnd   = tick && (m_phase == per - 1);
            cnt_v = (m_mode && m_phase > MAXV - 1) ? per - m_phase : m_phase;
            for (int i = 0; i < NUM_CH; i++)
                m_out[i] = en_out[i] & (en_pwm[i] ? (cnt_v < int'(m_duty[i])) : 1'b1);
            m_presc = tick ? 0 : m_presc + 1;
            if (tick) m_phase = bnd ? 0 : m_phase + 1;
            m_ack = 1'b0;
            if (bnd && (m_pend || load_req)) begin
                for (int i = 0; i < NUM_CH; i++) m_duty[i] = duty[i*DUTY_W +: DUTY_W];
                m_mode = center_mode;
                m_pend = 1'b0;
                m_ack  = 1'b1;
            end else if (load_req) begin
                m_pend = 1'b1;
            end
            m_pt = bnd;
        end
        sb_q.push_back('{out: m_out, pt: m_pt, ack: m_ack, pend: m_pend});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("out", 64'(out), 64'(e.out));
        check("flags", 64'({period_tick, upd_ack, upd_pending}), 64'({e.pt, e.ack, e.pend}));
    endtask

    task automatic run(input int n);
        st_n = 0; st_hi0 = 0; st_hi1 = 0; st_hi2 = 0;
        st_pt = 0; st_pt_pos = 0; st_ack = 0; st_or = '0;
        for (int k = 0; k < n; k++) begin
            step();
            st_n++;
            if (out[0]) st_hi0++;
            if (out[1]) st_hi1++;
            if (out[2]) st_hi2++;
            if (period_tick) begin st_pt++; st_pt_pos = st_n; end
            if (upd_ack) st_ack++;
            st_or = st_or | out;
            if (st_n < 2048) hist[st_n] = out[0];
        end
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int bound);
        int k;
        k = 0;
        while (!upd_ack && k < bound) begin
            step();
            k++;
        end
        check({tag, "_ack_seen"}, 64'(upd_ack), 64'(1));
        check({tag, "_ack_with_pt"}, 64'(period_tick), 64'(1));
    endtask

    initial begin
        model_reset();
        // 1: reset, static-high channels
        en_out = '1;
        en_pwm = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 64'(out), 64'(0));
        check("rst_flags", 64'({period_tick, upd_ack, upd_pending}), 64'(0));
        rst = 1'b0;
        step();
        check("t1_out_high", 64'(out), 64'({NUM_CH{1'b1}}));
        run(20);
        check("t1_no_pt", 64'(st_pt + st_ack), 64'(0));

        // 2: edge mode, prescale 0
        en_pwm = '1;
        for (int i = 3; i < NUM_CH; i++) begin
            set_duty(i, int'($urandom_range(0, MAXV)));
            en_pwm[i] = 1'($urandom_range(0, 1));
        end
        set_duty(0, 8'h80); set_duty(1, 8'h00); set_duty(2, 8'hFF);
        pulse_load();
        wait_ack("t2", 600);
        run(255);
        check("t2_ch0_high", 64'(st_hi0), 64'(128));
        check("t2_ch1_high", 64'(st_hi1), 64'(0));
        check("t2_ch2_high", 64'(st_hi2), 64'(255));
        check("t2_pt_count", 64'(st_pt), 64'(1));
        check("t2_pt_pos", 64'(st_pt_pos), 64'(255));

        // 3: prescale 3
        prescale = 8'd3;
        set_duty(0, 8'h40);
        pulse_load();
        wait_ack("t3", 1200);
        run(1020);
        check("t3_ch0_high", 64'(st_hi0), 64'(256));
        check("t3_pt_count", 64'(st_pt), 64'(1));
        check("t3_pt_pos", 64'(st_pt_pos), 64'(1020));

        // 4: center mode commit
        prescale = 8'd0;
        center_mode = 1'b1;
        set_duty(0, 8'h10);
        pulse_load();
        wait_ack("t4", 1200);
        run(508);
        check("t4_ch0_high", 64'(st_hi0), 64'(31));
        check("t4_pt_pos", 64'(st_pt_pos), 64'(508));
        check("t4_start_hi", 64'({hist[1], hist[16], hist[17]}), 64'(3'b110));
        check("t4_end_hi", 64'({hist[493], hist[494], hist[508]}), 64'(3'b011));

        // 5: mid-period update with double request
        center_mode = 1'b0;
        set_duty(0, 8'h80);
        pulse_load();
        wait_ack("t5a", 600);
        run(100);
        set_duty(0, 8'h20);
        pulse_load();
        step();
        pulse_load();
        check("t5_pending", 64'(upd_pending), 64'(1));
        wait_ack("t5", 300);
        run(255);
        check("t5_ch0_high", 64'(st_hi0), 64'(32));
        check("t5_single_ack", 64'(st_ack), 64'(0));
        check("t5_pt_pos", 64'(st_pt_pos), 64'(255));

        // 6: reset mid-period with an update pending
        run(50);
        set_duty(0, 8'h60);
        pulse_load();
        check("t6_pending", 64'(upd_pending), 64'(1));
        en_pwm = '1;
        rst = 1'b1;
        #1;
        check("t6_rst_out", 64'(out), 64'(0));
        check("t6_rst_pend", 64'(upd_pending), 64'(0));
        model_reset();
        step();
        step();
        rst = 1'b0;
        run(300);
        check("t6_low_after", 64'(st_or), 64'(0));
        check("t6_no_ack", 64'(st_ack), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
